// File: rtl/adc_unfold_offset_cal.sv
// ============================================================================
// Module   : adc_unfold_offset_cal
// Purpose  : Unfolds a sign+magnitude ADC slice code, removes the PFD offset,
//            estimates that offset by decimated averaging, and bins dead-zone hits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_unfold_offset_cal #(
  parameter int NADC     = 8,
  parameter int NAVG_MAX = 10,
  parameter int HIST_W   = 24,
  parameter int NBIN_MAX = 20,
  localparam int SUM_W   = NADC + 1 + NAVG_MAX
) (
  input  logic              clk_retimer,
  input  logic              rst,
  input  logic [NADC-1:0]   din,
  input  logic              sign_out,
  input  logic              avg_tick,
  input  logic              en_pfd_cal,
  input  logic              en_ext_pfd_offset,
  input  logic [NADC-1:0]   ext_pfd_offset,
  input  logic [3:0]        Navg,
  input  logic [4:0]        Nbin,
  input  logic [NADC-2:0]   DZ,
  output logic [NADC-1:0]   dout,
  output logic [NADC-1:0]   dout_avg,
  output logic [SUM_W-1:0]  dout_sum,
  output logic [HIST_W-1:0] hist_center,
  output logic [HIST_W-1:0] hist_side,
  output logic [NADC-1:0]   pfd_offset
);

  localparam logic [3:0]              NAVG_CAP = 4'(NAVG_MAX);
  localparam logic [4:0]              NBIN_CAP = 5'(NBIN_MAX);
  localparam logic [NAVG_MAX:0]       AVG_ONE  = (NAVG_MAX+1)'(1);
  localparam logic [NBIN_MAX:0]       BIN_ONE  = (NBIN_MAX+1)'(1);
  localparam logic [HIST_W-1:0]       HIST_ONE = HIST_W'(1);
  localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((2**(NADC-1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN  = ~SAT_MAX;

  function automatic logic [NADC-1:0] sat_n(input logic signed [SUM_W-1:0] x);
    if (x > SAT_MAX)      sat_n = SAT_MAX[NADC-1:0];
    else if (x < SAT_MIN) sat_n = SAT_MIN[NADC-1:0];
    else                  sat_n = x[NADC-1:0];
  endfunction

  logic [NADC-1:0]          dout_q;
  logic signed [NADC-1:0]   pfd_offset_q;
  logic [NADC-1:0]          cal_offset_q;
  logic [NADC-1:0]          dout_avg_q;
  logic signed [SUM_W-1:0]  dout_sum_q;
  logic signed [SUM_W-1:0]  acc_q;
  logic [NAVG_MAX:0]        cnt_q;
  logic [HIST_W-1:0]        hist_center_q, hist_side_q;
  logic [HIST_W-1:0]        hcc_q, hcs_q;
  logic [NBIN_MAX:0]        hcnt_q;

  // Output path: unfold, subtract offset at NADC+2 bits, saturate
  logic signed [NADC:0]     raw_w;
  logic signed [NADC+1:0]   corr_w;
  logic signed [SUM_W-1:0]  corr_ext_w;
  logic [NADC-1:0]          dout_d;
  logic [NADC-1:0]          pfd_offset_d;

  assign raw_w        = sign_out ? $signed({1'b0, din}) : -$signed({1'b0, din});
  assign corr_w       = {raw_w[NADC], raw_w} - {{2{pfd_offset_q[NADC-1]}}, pfd_offset_q};
  assign corr_ext_w   = {{(SUM_W-NADC-2){corr_w[NADC+1]}}, corr_w};
  assign dout_d       = sat_n(corr_ext_w);
  assign pfd_offset_d = en_ext_pfd_offset ? ext_pfd_offset : cal_offset_q;

  // Average engine
  logic [3:0]               navg_eff_w;
  logic [NAVG_MAX:0]        avg_len_w;
  logic [NAVG_MAX:0]        cnt_d;
  logic signed [SUM_W-1:0]  acc_d;
  logic [NADC-1:0]          avg_d;
  logic                     avg_end_w;

  assign navg_eff_w = (Navg > NAVG_CAP) ? NAVG_CAP : Navg;
  assign avg_len_w  = AVG_ONE << navg_eff_w;
  assign cnt_d      = cnt_q + AVG_ONE;
  assign acc_d      = acc_q + {{(SUM_W-NADC-1){raw_w[NADC]}}, raw_w};
  assign avg_d      = sat_n(acc_d >>> navg_eff_w);
  assign avg_end_w  = (cnt_d >= avg_len_w);

  // Histogram engine; |-2^(NADC-1)| wraps to 2^(NADC-1) as an unsigned magnitude
  logic [4:0]               nbin_eff_w;
  logic [NBIN_MAX:0]        hist_len_w;
  logic [NBIN_MAX:0]        hcnt_d;
  logic [NADC-1:0]          mag_w;
  logic                     in_center_w;
  logic                     hist_end_w;
  logic [HIST_W-1:0]        hcc_d, hcs_d;

  assign nbin_eff_w  = (Nbin > NBIN_CAP) ? NBIN_CAP : Nbin;
  assign hist_len_w  = BIN_ONE << nbin_eff_w;
  assign hcnt_d      = hcnt_q + BIN_ONE;
  assign hist_end_w  = (hcnt_d >= hist_len_w);
  assign mag_w       = dout_q[NADC-1] ? ('0 - dout_q) : dout_q;
  assign in_center_w = (mag_w <= {1'b0, DZ});
  assign hcc_d       = (in_center_w && (hcc_q != '1)) ? hcc_q + HIST_ONE : hcc_q;
  assign hcs_d       = (!in_center_w && (hcs_q != '1)) ? hcs_q + HIST_ONE : hcs_q;

  always_ff @(posedge clk_retimer or posedge rst) begin
    if (rst) begin
      dout_q        <= '0;
      pfd_offset_q  <= '0;
      cal_offset_q  <= '0;
      dout_avg_q    <= '0;
      dout_sum_q    <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      hist_center_q <= '0;
      hist_side_q   <= '0;
      hcc_q         <= '0;
      hcs_q         <= '0;
      hcnt_q        <= '0;
    end else begin
      dout_q       <= dout_d;
      pfd_offset_q <= pfd_offset_d;
      if (avg_tick) begin
        if (avg_end_w) begin
          dout_sum_q <= acc_d;
          dout_avg_q <= avg_d;
          acc_q      <= '0;
          cnt_q      <= '0;
          if (en_pfd_cal) cal_offset_q <= avg_d;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
        if (hist_end_w) begin
          hist_center_q <= hcc_d;
          hist_side_q   <= hcs_d;
          hcc_q         <= '0;
          hcs_q         <= '0;
          hcnt_q        <= '0;
        end else begin
          hcc_q  <= hcc_d;
          hcs_q  <= hcs_d;
          hcnt_q <= hcnt_d;
        end
      end
    end
  end

  assign dout        = dout_q;
  assign pfd_offset  = pfd_offset_q;
  assign dout_avg    = dout_avg_q;
  assign dout_sum    = dout_sum_q;
  assign hist_center = hist_center_q;
  assign hist_side   = hist_side_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_unfold_offset_cal.sv
// ============================================================================
// Module   : tb_adc_unfold_offset_cal
// Purpose  : Directed and random stimulus against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_unfold_offset_cal;

  logic        clk_retimer = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        sign_out;
  logic        avg_tick;
  logic        en_pfd_cal;
  logic        en_ext_pfd_offset;
  logic [7:0]  ext_pfd_offset;
  logic [3:0]  Navg;
  logic [4:0]  Nbin;
  logic [6:0]  DZ;
  logic [7:0]  dout;
  logic [7:0]  dout_avg;
  logic [18:0] dout_sum;
  logic [23:0] hist_center;
  logic [23:0] hist_side;
  logic [7:0]  pfd_offset;

  always #5 clk_retimer = ~clk_retimer;

  adc_unfold_offset_cal dut (
    .clk_retimer       (clk_retimer),
    .rst               (rst),
    .din               (din),
    .sign_out          (sign_out),
    .avg_tick          (avg_tick),
    .en_pfd_cal        (en_pfd_cal),
    .en_ext_pfd_offset (en_ext_pfd_offset),
    .ext_pfd_offset    (ext_pfd_offset),
    .Navg              (Navg),
    .Nbin              (Nbin),
    .DZ                (DZ),
    .dout              (dout),
    .dout_avg          (dout_avg),
    .dout_sum          (dout_sum),
    .hist_center       (hist_center),
    .hist_side         (hist_side),
    .pfd_offset        (pfd_offset)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_dout, m_pfd, m_cal, m_avg, m_sum, m_hc, m_hs;
  int m_acc, m_cnt, m_cc, m_cs, m_hcnt;

  function automatic int sat8(int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int floor_div(int s, int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic int sx8(logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx19(logic [18:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    m_dout = 0; m_pfd = 0; m_cal = 0; m_avg = 0; m_sum = 0; m_hc = 0; m_hs = 0;
    m_acc = 0; m_cnt = 0; m_cc = 0; m_cs = 0; m_hcnt = 0;
  endtask

  task automatic model_clock();
    int raw, nd, np, n, wlen, s, mag;
    if (rst) begin
      model_reset();
      return;
    end
    raw = sign_out ? int'(din) : -int'(din);
    nd  = sat8(raw - m_pfd);
    np  = en_ext_pfd_offset ? sx8(ext_pfd_offset) : m_cal;
    if (avg_tick) begin
      n    = (Navg > 10) ? 10 : int'(Navg);
      wlen = 1 << n;
      if (m_cnt + 1 >= wlen) begin
        s     = m_acc + raw;
        m_sum = s;
        m_avg = sat8(floor_div(s, wlen));
        if (en_pfd_cal) m_cal = m_avg;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc = m_acc + raw;
        m_cnt = m_cnt + 1;
      end
      mag = (m_dout < 0) ? -m_dout : m_dout;
      if (mag <= int'(DZ)) m_cc = (m_cc < 24'hFFFFFF) ? m_cc + 1 : m_cc;
      else                 m_cs = (m_cs < 24'hFFFFFF) ? m_cs + 1 : m_cs;
      n    = (Nbin > 20) ? 20 : int'(Nbin);
      wlen = 1 << n;
      if (m_hcnt + 1 >= wlen) begin
        m_hc = m_cc; m_hs = m_cs;
        m_cc = 0; m_cs = 0; m_hcnt = 0;
      end else begin
        m_hcnt = m_hcnt + 1;
      end
    end
    m_dout = nd;
    m_pfd  = np;
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".dout"},        sx8(dout),         m_dout);
    chk({tag, ".pfd_offset"},  sx8(pfd_offset),   m_pfd);
    chk({tag, ".dout_avg"},    sx8(dout_avg),     m_avg);
    chk({tag, ".dout_sum"},    sx19(dout_sum),    m_sum);
    chk({tag, ".hist_center"}, int'(hist_center), m_hc);
    chk({tag, ".hist_side"},   int'(hist_side),   m_hs);
  endtask

  task automatic step(string tag);
    @(posedge clk_retimer);
    model_clock();
    #1;
    check_all(tag);
  endtask

  task automatic drive_raw(int r);
    sign_out = (r >= 0);
    din      = 8'((r < 0) ? -r : r);
  endtask

  // Asynchronous reset pulse starting between edges, held across one edge
  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    step(tag);
    rst = 1'b0;
  endtask

  initial begin
    int hv [4];
    rst = 1'b1; din = '0; sign_out = 1'b1; avg_tick = 1'b0; en_pfd_cal = 1'b0;
    en_ext_pfd_offset = 1'b0; ext_pfd_offset = '0; Navg = '0; Nbin = '0; DZ = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.dout_const", sx8(dout), 0);
    rst = 1'b0;

    // Unfold with zero offset
    din = 8'd37; sign_out = 1'b1;
    step("pos37");
    chk("pos37.const", sx8(dout), 37);
    sign_out = 1'b0;
    step("neg37");
    chk("neg37.const", sx8(dout), -37);

    // External offset and saturation
    en_ext_pfd_offset = 1'b1; ext_pfd_offset = 8'd5; drive_raw(-100);
    step("ext5a");
    chk("ext5.pfd_const", sx8(pfd_offset), 5);
    step("ext5b");
    chk("ext5.dout_const", sx8(dout), -105);
    ext_pfd_offset = 8'(-10); drive_raw(127);
    step("extm10a");
    step("extm10b");
    chk("sat_pos.const", sx8(dout), 127);
    drive_raw(-128); ext_pfd_offset = 8'd127;
    step("sat_neg_a");
    step("sat_neg_b");
    chk("sat_neg.const", sx8(dout), -128);

    // Calibration loop, Navg=3, constant +6
    do_reset("rst1");
    en_ext_pfd_offset = 1'b0; en_pfd_cal = 1'b1; Navg = 4'd3; avg_tick = 1'b1;
    drive_raw(6);
    for (int i = 0; i < 8; i++) step("cal");
    chk("cal.sum_const", sx19(dout_sum), 48);
    chk("cal.avg_const", sx8(dout_avg), 6);
    avg_tick = 1'b0;
    step("cal_pfd");
    chk("cal.pfd_const", sx8(pfd_offset), 6);
    step("cal_dout");
    chk("cal.dout_const", sx8(dout), 0);

    // Decimated average, Navg=2, strobe every 3rd cycle, +4/-2
    do_reset("rst2");
    en_pfd_cal = 1'b0; Navg = 4'd2;
    for (int i = 0; i < 12; i++) begin
      avg_tick = (i % 3 == 2);
      drive_raw(((i / 3) % 2 == 0) ? 4 : -2);
      step("dec");
    end
    avg_tick = 1'b0;
    chk("dec.sum_const", sx19(dout_sum), 4);
    chk("dec.avg_const", sx8(dout_avg), 1);
    chk("dec.pfd_const", sx8(pfd_offset), 0);

    // Dead-zone histogram, Nbin=2, DZ=3
    do_reset("rst3");
    en_ext_pfd_offset = 1'b1; ext_pfd_offset = '0; Nbin = 5'd2; DZ = 7'd3;
    hv[0] = 0; hv[1] = 3; hv[2] = -4; hv[3] = 10;
    drive_raw(hv[0]); avg_tick = 1'b0;
    step("hist0");
    for (int k = 1; k <= 4; k++) begin
      drive_raw((k < 4) ? hv[k] : 0);
      avg_tick = 1'b1;
      step("hist");
    end
    avg_tick = 1'b0;
    chk("hist.center_const", int'(hist_center), 2);
    chk("hist.side_const",   int'(hist_side),   2);

    // Reset mid-window then a full fresh window
    do_reset("rst4");
    Navg = 4'd4; avg_tick = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_raw(int'($urandom_range(0, 200)) - 100);
      step("pre_rst");
    end
    rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_rst");
    chk("mid_rst.sum_const", sx19(dout_sum), 0);
    step("mid_rst_hold");
    rst = 1'b0;
    drive_raw(5);
    for (int i = 0; i < 15; i++) step("post_rst");
    chk("post_rst.early_const", sx19(dout_sum), 0);
    step("post_rst_last");
    chk("post_rst.sum_const", sx19(dout_sum), 80);

    // Randomized traffic
    do_reset("rst5");
    for (int i = 0; i < 900; i++) begin
      if (i % 40 == 0) begin
        Navg = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 4));
        Nbin = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 4));
        DZ   = 7'($urandom_range(0, 127));
        en_pfd_cal = 1'($urandom_range(0, 1));
      end
      din               = 8'($urandom_range(0, 255));
      sign_out          = 1'($urandom_range(0, 1));
      avg_tick          = 1'($urandom_range(0, 1));
      en_ext_pfd_offset = ($urandom_range(0, 3) == 0);
      ext_pfd_offset    = 8'($urandom_range(0, 255));
      if (i % 300 == 299) do_reset("rand_rst");
      else                step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
